// File: rtl/axis_bulk_framer.sv
// axis_bulk_framer: closes bulk IN packets at max size, on upstream tlast,
// or after an idle timeout, using a one-byte look-ahead hold stage.
//
// Ports:
//   aclk, reset            - clock, synchronous active-high reset
//   s_axis_tvalid_i        - upstream byte valid
//   s_axis_tready_o        - upstream ready (low while reset is high)
//   s_axis_tlast_i         - upstream end-of-packet request
//   s_axis_tdata_i[7:0]    - upstream byte
//   m_axis_tvalid_o        - framed byte valid (registered)
//   m_axis_tready_i        - endpoint ready
//   m_axis_tlast_o         - packet end (registered)
//   m_axis_tdata_o[7:0]    - framed byte (registered)
//
// Parameters:
//   MAX_PACKET   - bytes per full packet (2..4096)
//   IDLE_TIMEOUT - idle cycles before a held byte is flushed (1..65535)

module axis_bulk_framer #(
    parameter int MAX_PACKET   = 512,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       aclk,
    input  logic       reset,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic       s_axis_tlast_i,
    input  logic [7:0] s_axis_tdata_i,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       m_axis_tlast_o,
    output logic [7:0] m_axis_tdata_o
);

    localparam int CW = $clog2(MAX_PACKET);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PACKET - 1);
    localparam logic [TW-1:0] TMO      = TW'(IDLE_TIMEOUT);

    // Output stage: drives m_axis_* directly.
    logic          r_o_valid;
    logic [7:0]    r_o_data;
    logic          r_o_last;

    // Hold stage: one byte of look-ahead.
    logic          r_h_valid;
    logic [7:0]    r_h_data;
    logic          r_h_last;

    // Bytes already moved to the output stage in the current packet.
    logic [CW-1:0] r_count;

    // Idle edges seen since the held byte last changed.
    logic [TW-1:0] r_timer;

    logic          w_o_free;
    logic          w_expired;
    logic          w_at_max;
    logic          w_close;
    logic          w_move;
    logic          w_s_ready;
    logic          w_accept;

    assign w_o_free  = !r_o_valid || m_axis_tready_i;

    // The timer reaches IDLE_TIMEOUT on the IDLE_TIMEOUT-th idle edge
    // after an accept; the close then lands on the following edge, so
    // the flushed byte shows up IDLE_TIMEOUT+1 edges after its accept.
    assign w_expired = (r_timer == TMO);

    assign w_at_max  = (r_count == LAST_IDX);

    // All close causes fold into one flag: a single tlast, a single
    // count reset, never an extra empty packet.
    assign w_close   = r_h_last || w_at_max || w_expired;

    // A held byte only leaves once its successor is on the input or the
    // packet is being closed, so tlast can still be attached to it.
    assign w_move    = !reset && r_h_valid && w_o_free &&
                       (s_axis_tvalid_i || w_close);

    assign w_s_ready = !reset && (!r_h_valid || w_move);
    assign w_accept  = s_axis_tvalid_i && w_s_ready;

    assign s_axis_tready_o = w_s_ready;
    assign m_axis_tvalid_o = r_o_valid;
    assign m_axis_tlast_o  = r_o_last;
    assign m_axis_tdata_o  = r_o_data;

    // Output stage. Data and last only change on a move, which requires
    // the stage to be free, so they stay frozen while stalled.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_o_valid <= 1'b0;
            r_o_data  <= 8'h00;
            r_o_last  <= 1'b0;
        end else if (w_move) begin
            r_o_valid <= 1'b1;
            r_o_data  <= r_h_data;
            r_o_last  <= w_close;
        end else if (r_o_valid && m_axis_tready_i) begin
            r_o_valid <= 1'b0;
        end
    end

    // Hold stage. An accept and a move on the same edge refill it.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_h_valid <= 1'b0;
            r_h_data  <= 8'h00;
            r_h_last  <= 1'b0;
        end else if (w_accept) begin
            r_h_valid <= 1'b1;
            r_h_data  <= s_axis_tdata_i;
            r_h_last  <= s_axis_tlast_i;
        end else if (w_move) begin
            r_h_valid <= 1'b0;
        end
    end

    // Packet byte counter.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_move) begin
            if (w_close) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Idle timer. Saturates so an expiry reached while the output is
    // blocked is remembered until the byte finally moves.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_accept || w_move) begin
            r_timer <= '0;
        end else if (!r_h_valid) begin
            r_timer <= '0;
        end else if (!w_expired) begin
            r_timer <= r_timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_axis_bulk_framer.sv
// Scoreboard bench for axis_bulk_framer with MAX_PACKET=4, IDLE_TIMEOUT=8.
// Stimulus pushes hand-computed {last,data}; a monitor pops on handshakes.

module tb_axis_bulk_framer;

    logic       aclk;
    logic       reset;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] s_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic [7:0] m_tdata;

    axis_bulk_framer #(
        .MAX_PACKET   (4),
        .IDLE_TIMEOUT (8)
    ) dut (
        .aclk            (aclk),
        .reset           (reset),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .s_axis_tlast_i  (s_tlast),
        .s_axis_tdata_i  (s_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tlast_o  (m_tlast),
        .m_axis_tdata_o  (m_tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acc    = 0;

    logic [8:0] exp_q[$];
    int         acc_cyc[256];
    int         seen[256];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Monitor: scoreboard pop on each handshake, stability while stalled.
    bit         new_beat   = 1'b1;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_out;

    initial begin
        forever begin
            @(negedge aclk);
            if (reset) begin
                new_beat   = 1'b1;
                prev_stall = 1'b0;
            end else if (m_tvalid) begin
                if (new_beat) seen[m_tdata] = cyc;
                if (prev_stall) chk("stall_stable", int'({m_tlast, m_tdata}), int'(prev_out));
                if (m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL out_unexpected: got data 0x%0h last %0b, expected nothing", m_tdata, m_tlast);
                    end else begin
                        chk("out_beat", int'({m_tlast, m_tdata}), int'(exp_q.pop_front()));
                    end
                    new_beat   = 1'b1;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_out   = {m_tlast, m_tdata};
                    new_beat   = 1'b0;
                end
            end else begin
                if (prev_stall) chk("valid_held_in_stall", 0, 1);
                new_beat   = 1'b1;
                prev_stall = 1'b0;
            end
        end
    end

    // Present one byte until accepted; optionally expect it on the output.
    task automatic send(input logic [7:0] d, input logic l,
                        input logic el, input bit push);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        if (push) exp_q.push_back({el, d});
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!acc && t < 60) begin
            @(negedge aclk);
            acc = s_tready;
            @(posedge aclk);
            #1;
            t++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        acc_cyc[d] = cyc;
        n_acc++;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge aclk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    int a0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            seen[i]    = -1;
            acc_cyc[i] = -1;
        end
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        m_tready = 1'b1;
        idle(3);
        @(negedge aclk);
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tlast", int'(m_tlast), 0);
        chk("rst_tdata", int'(m_tdata), 0);
        chk("rst_tready", int'(s_tready), 0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(negedge aclk);
        chk("post_rst_tready", int'(s_tready), 1);
        @(posedge aclk);
        #1;

        // Continuous stream, flushed on idle.
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 1'b0, (i == 3 || i == 7 || i == 9), 1'b1);
        end
        drain();
        chk("stream_flush_lat", seen[8'h09] - acc_cyc[8'h09], 9);
        for (int k = 1; k < 8; k++) begin
            chk("stream_no_gap", seen[k+1] - seen[k], 1);
        end

        // Single bytes.
        send(8'hA5, 1'b0, 1'b1, 1'b1);
        drain();
        chk("single_a5_lat", seen[8'hA5] - acc_cyc[8'hA5], 9);
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        drain();
        chk("single_5a_lat", seen[8'h5A] - acc_cyc[8'h5A], 9);

        // Upstream tlast.
        send(8'h10, 1'b0, 1'b0, 1'b1);
        send(8'h11, 1'b1, 1'b1, 1'b1);
        idle(3);
        chk("ulast_11_lat", seen[8'h11] - acc_cyc[8'h11], 1);
        send(8'h12, 1'b0, 1'b0, 1'b1);
        send(8'h13, 1'b0, 1'b0, 1'b1);
        send(8'h14, 1'b0, 1'b0, 1'b1);
        send(8'h15, 1'b0, 1'b1, 1'b1);
        drain();
        chk("maxsize_15_lat", seen[8'h15] - acc_cyc[8'h15], 1);

        // Backpressure mid-packet.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(8'h20 + 8'(i), 1'b0, (i % 4 == 3), 1'b1);
                end
            end
            begin
                idle(6);
                m_tready = 1'b0;
                a0 = n_acc;
                idle(5);
                chk("bp_accepts_le2", int'((n_acc - a0) <= 2), 1);
                m_tready = 1'b1;
            end
        join
        drain();

        // Expiry while the output is stalled.
        m_tready = 1'b0;
        send(8'h40, 1'b0, 1'b1, 1'b1);
        idle(12);
        chk("stall_o_full", int'(m_tvalid), 1);
        send(8'h30, 1'b0, 1'b1, 1'b1);
        idle(12);
        m_tready = 1'b1;
        send(8'h31, 1'b0, 1'b0, 1'b1);
        send(8'h32, 1'b0, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b1, 1'b1);
        drain();

        // Reset with both stages full.
        m_tready = 1'b0;
        send(8'h50, 1'b0, 1'b0, 1'b0);
        send(8'h51, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_o_full", int'(m_tvalid), 1);
        reset = 1'b1;
        @(negedge aclk);
        chk("mid_rst_tready", int'(s_tready), 0);
        @(posedge aclk);
        #1;
        chk("mid_rst_tvalid", int'(m_tvalid), 0);
        reset    = 1'b0;
        m_tready = 1'b1;
        @(negedge aclk);
        chk("after_rst_tready", int'(s_tready), 1);
        @(posedge aclk);
        #1;
        send(8'h60, 1'b0, 1'b0, 1'b1);
        send(8'h61, 1'b0, 1'b0, 1'b1);
        send(8'h62, 1'b0, 1'b0, 1'b1);
        send(8'h63, 1'b0, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
